// File: rtl/id_ex_stage_if.sv
// Bundle for the ID/EX stage: the fetch-side and regfile inputs plus the execute-side slot.
// The slave modport is the stage itself; the master modport is everything around it.
interface id_ex_stage_if #(
   parameter int XLEN = 64
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [31:0]     in_inst;
   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            ex_valid;
   logic            ex_ready;
   logic [3:0]      ex_aluop;
   logic [XLEN-1:0] ex_op1;
   logic [XLEN-1:0] ex_op2;
   logic [XLEN-1:0] ex_imm;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_store_data;
   logic [4:0]      ex_rd;
   logic            ex_wen;
   logic [2:0]      ex_class;
   logic [2:0]      ex_funct3;
   logic            ex_word;
   logic            ex_illegal;

   modport slave (
      input  flush, in_valid, in_pc, in_inst, rs1_data, rs2_data, ex_ready,
      output in_ready, rs1_addr, rs2_addr, ex_valid, ex_aluop, ex_op1, ex_op2,
             ex_imm, ex_pc, ex_store_data, ex_rd, ex_wen, ex_class, ex_funct3,
             ex_word, ex_illegal
   );

   modport master (
      output flush, in_valid, in_pc, in_inst, rs1_data, rs2_data, ex_ready,
      input  in_ready, rs1_addr, rs2_addr, ex_valid, ex_aluop, ex_op1, ex_op2,
             ex_imm, ex_pc, ex_store_data, ex_rd, ex_wen, ex_class, ex_funct3,
             ex_word, ex_illegal
   );
endinterface

// File: rtl/id_ex_stage.sv
// RV64I decode stage with a one-deep ID/EX register slot toward the execute-stage ALU.
// Regfile addresses and in_ready are combinational; everything on the ex_* side is registered.
module id_ex_stage #(
   parameter int XLEN = 64
) (
   input logic          clk,
   input logic          rst,
   id_ex_stage_if.slave bus
);
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP32   = 7'b0111011;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   localparam logic [2:0] CLS_ALU = 3'd0, CLS_LOAD = 3'd1, CLS_STORE = 3'd2;
   localparam logic [2:0] CLS_BRANCH = 3'd3, CLS_JAL = 3'd4, CLS_JALR = 3'd5;

   // funct3 to aluop; alt selects SUB for add and arithmetic for right shift.
   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  alu_from_f3 = {3'b000, alt};
         3'b001:  alu_from_f3 = 4'b1000;
         3'b010:  alu_from_f3 = 4'b1100;
         3'b011:  alu_from_f3 = 4'b1110;
         3'b100:  alu_from_f3 = 4'b0100;
         3'b101:  alu_from_f3 = {2'b10, alt, 1'b1};
         3'b110:  alu_from_f3 = 4'b0110;
         default: alu_from_f3 = 4'b0111;
      endcase
   endfunction

   logic [31:0]     inst_s;
   logic [6:0]      opcode_s;
   logic [2:0]      f3_s;
   logic [6:0]      f7_s;
   logic            in_ready_s;
   logic            load_s;
   logic [XLEN-1:0] rs1_val_s, rs2_val_s;
   logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, sh6_s, sh5_s;
   logic [XLEN-1:0] pc_s, four_s, zero_s;

   logic [3:0]      aluop_s;
   logic [XLEN-1:0] op1_s, op2_s, imm_s;
   logic [2:0]      class_s;
   logic            word_s, legal_s, writes_s;

   logic            ex_valid_r, ex_wen_r, ex_word_r, ex_illegal_r;
   logic [3:0]      ex_aluop_r;
   logic [XLEN-1:0] ex_op1_r, ex_op2_r, ex_imm_r, ex_pc_r, ex_store_data_r;
   logic [4:0]      ex_rd_r;
   logic [2:0]      ex_class_r, ex_funct3_r;

   assign inst_s   = bus.in_inst;
   assign pc_s     = bus.in_pc;
   assign opcode_s = inst_s[6:0];
   assign f3_s     = inst_s[14:12];
   assign f7_s     = inst_s[31:25];
   assign zero_s   = {XLEN{1'b0}};
   assign four_s   = {{(XLEN-3){1'b0}}, 3'd4};

   assign bus.rs1_addr = inst_s[19:15];
   assign bus.rs2_addr = inst_s[24:20];
   assign rs1_val_s    = (inst_s[19:15] == 5'd0) ? zero_s : bus.rs1_data;
   assign rs2_val_s    = (inst_s[24:20] == 5'd0) ? zero_s : bus.rs2_data;

   assign imm_i_s = {{(XLEN-12){inst_s[31]}}, inst_s[31:20]};
   assign imm_s_s = {{(XLEN-12){inst_s[31]}}, inst_s[31:25], inst_s[11:7]};
   assign imm_b_s = {{(XLEN-13){inst_s[31]}}, inst_s[31], inst_s[7], inst_s[30:25], inst_s[11:8], 1'b0};
   assign imm_u_s = {{(XLEN-32){inst_s[31]}}, inst_s[31:12], 12'h000};
   assign imm_j_s = {{(XLEN-21){inst_s[31]}}, inst_s[31], inst_s[19:12], inst_s[20], inst_s[30:21], 1'b0};
   assign sh6_s   = {{(XLEN-6){1'b0}}, inst_s[25:20]};
   assign sh5_s   = {{(XLEN-5){1'b0}}, inst_s[24:20]};

   assign in_ready_s   = !ex_valid_r || bus.ex_ready;
   assign bus.in_ready = in_ready_s;
   assign load_s       = bus.in_valid && in_ready_s && !bus.flush;

   // Instruction decode: operand muxing, aluop, class and legality.
   always_comb begin
      aluop_s  = 4'b0000;
      op1_s    = rs1_val_s;
      op2_s    = rs2_val_s;
      imm_s    = zero_s;
      class_s  = CLS_ALU;
      word_s   = 1'b0;
      legal_s  = 1'b1;
      writes_s = 1'b0;
      case (opcode_s)
         OPC_OP: begin
            writes_s = 1'b1;
            aluop_s  = alu_from_f3(f3_s, inst_s[30]);
            legal_s  = (f7_s == 7'd0) || ((f7_s == F7_ALT) && (f3_s == 3'b000 || f3_s == 3'b101));
         end
         OPC_OP32: begin
            writes_s = 1'b1;
            word_s   = 1'b1;
            aluop_s  = alu_from_f3(f3_s, inst_s[30]);
            legal_s  = (f3_s == 3'b000 || f3_s == 3'b101) ? ((f7_s == 7'd0) || (f7_s == F7_ALT))
                                                          : ((f3_s == 3'b001) && (f7_s == 7'd0));
         end
         OPC_OPIMM: begin
            writes_s = 1'b1;
            imm_s    = imm_i_s;
            aluop_s  = alu_from_f3(f3_s, (f3_s == 3'b101) && inst_s[30]);
            op2_s    = (f3_s == 3'b001 || f3_s == 3'b101) ? sh6_s : imm_i_s;
            legal_s  = (f3_s == 3'b001) ? (inst_s[31:26] == 6'd0) :
                       (f3_s == 3'b101) ? (inst_s[31:26] == 6'd0 || inst_s[31:26] == 6'b010000) : 1'b1;
         end
         OPC_OPIMM32: begin
            writes_s = 1'b1;
            word_s   = 1'b1;
            imm_s    = imm_i_s;
            aluop_s  = alu_from_f3(f3_s, (f3_s == 3'b101) && inst_s[30]);
            op2_s    = (f3_s == 3'b000) ? imm_i_s : sh5_s;
            legal_s  = (f3_s == 3'b000) || ((f3_s == 3'b001) && (f7_s == 7'd0)) ||
                       ((f3_s == 3'b101) && ((f7_s == 7'd0) || (f7_s == F7_ALT)));
         end
         OPC_LUI: begin
            writes_s = 1'b1;
            op1_s    = zero_s;
            op2_s    = imm_u_s;
            imm_s    = imm_u_s;
         end
         OPC_AUIPC: begin
            writes_s = 1'b1;
            op1_s    = pc_s;
            op2_s    = imm_u_s;
            imm_s    = imm_u_s;
         end
         OPC_LOAD: begin
            writes_s = 1'b1;
            class_s  = CLS_LOAD;
            op2_s    = imm_i_s;
            imm_s    = imm_i_s;
            legal_s  = (f3_s != 3'b111);
         end
         OPC_STORE: begin
            class_s = CLS_STORE;
            op2_s   = imm_s_s;
            imm_s   = imm_s_s;
            legal_s = !f3_s[2];
         end
         OPC_BRANCH: begin
            class_s = CLS_BRANCH;
            imm_s   = imm_b_s;
            aluop_s = f3_s[1] ? 4'b1110 : 4'b1100;
            legal_s = (f3_s[2:1] != 2'b01);
         end
         OPC_JAL: begin
            writes_s = 1'b1;
            class_s  = CLS_JAL;
            op1_s    = pc_s;
            op2_s    = four_s;
            imm_s    = imm_j_s;
         end
         OPC_JALR: begin
            writes_s = 1'b1;
            class_s  = CLS_JALR;
            op1_s    = pc_s;
            op2_s    = four_s;
            imm_s    = imm_i_s;
            legal_s  = (f3_s == 3'b000);
         end
         default: begin
            legal_s = 1'b0;
         end
      endcase
   end

   // ID/EX slot: reset clears it, flush kills it, a transfer loads it; illegal slots carry a neutral payload.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_r      <= 1'b0;
         ex_aluop_r      <= 4'b0000;
         ex_op1_r        <= {XLEN{1'b0}};
         ex_op2_r        <= {XLEN{1'b0}};
         ex_imm_r        <= {XLEN{1'b0}};
         ex_pc_r         <= {XLEN{1'b0}};
         ex_store_data_r <= {XLEN{1'b0}};
         ex_rd_r         <= 5'd0;
         ex_wen_r        <= 1'b0;
         ex_class_r      <= 3'd0;
         ex_funct3_r     <= 3'd0;
         ex_word_r       <= 1'b0;
         ex_illegal_r    <= 1'b0;
      end else begin
         if (bus.flush) begin
            ex_valid_r <= 1'b0;
         end else if (in_ready_s) begin
            ex_valid_r <= bus.in_valid;
         end else begin
            ex_valid_r <= ex_valid_r;
         end
         if (load_s) begin
            ex_aluop_r      <= legal_s ? aluop_s : 4'b0000;
            ex_op1_r        <= legal_s ? op1_s : {XLEN{1'b0}};
            ex_op2_r        <= legal_s ? op2_s : {XLEN{1'b0}};
            ex_imm_r        <= legal_s ? imm_s : {XLEN{1'b0}};
            ex_pc_r         <= pc_s;
            ex_store_data_r <= rs2_val_s;
            ex_rd_r         <= inst_s[11:7];
            ex_wen_r        <= legal_s && writes_s && (inst_s[11:7] != 5'd0);
            ex_class_r      <= legal_s ? class_s : CLS_ALU;
            ex_funct3_r     <= f3_s;
            ex_word_r       <= legal_s && word_s;
            ex_illegal_r    <= !legal_s;
         end else begin
            ex_aluop_r <= ex_aluop_r;
         end
      end
   end

   assign bus.ex_valid      = ex_valid_r;
   assign bus.ex_aluop      = ex_aluop_r;
   assign bus.ex_op1        = ex_op1_r;
   assign bus.ex_op2        = ex_op2_r;
   assign bus.ex_imm        = ex_imm_r;
   assign bus.ex_pc         = ex_pc_r;
   assign bus.ex_store_data = ex_store_data_r;
   assign bus.ex_rd         = ex_rd_r;
   assign bus.ex_wen        = ex_wen_r;
   assign bus.ex_class      = ex_class_r;
   assign bus.ex_funct3     = ex_funct3_r;
   assign bus.ex_word       = ex_word_r;
   assign bus.ex_illegal    = ex_illegal_r;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: an ISA mask/match table model plus a one-slot handshake model, checked every cycle.
module tb_id_ex_stage;
   logic clk;
   logic rst;
   id_ex_stage_if #(.XLEN(64)) bus ();

   id_ex_stage #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] mask, match;
      logic [3:0]  aluop;
      int          cls, a, b, ik;
      bit          word, wr;
   } ent_t;

   typedef struct {
      logic [3:0]  aluop;
      logic [63:0] op1, op2, imm, pc, sd;
      logic [4:0]  rd;
      logic        wen, word, ill;
      logic [2:0]  cls, f3;
      int          ik;
   } exp_t;

   ent_t tbl[$];
   exp_t m_exp;
   bit   m_valid, m_zero, m_known;
   int   total, bad;

   localparam logic [31:0] MU = 32'h0000007F, MI = 32'h0000707F, MR = 32'hFE00707F, MS = 32'hFC00707F;

   task automatic add(input logic [31:0] mask, input logic [31:0] match, input logic [3:0] aluop,
                      input int cls, input int a, input int b, input int ik, input bit word, input bit wr);
      ent_t e;
      e.mask = mask; e.match = match; e.aluop = aluop; e.cls = cls;
      e.a = a; e.b = b; e.ik = ik; e.word = word; e.wr = wr;
      tbl.push_back(e);
   endtask

   function automatic logic [63:0] sx(input logic [31:0] v, input int bits);
      longint t;
      t = longint'({32'h0, v}) << (64 - bits);
      return 64'(t >>> (64 - bits));
   endfunction

   // Reference: find the instruction in the ISA table, then assemble the operands it names.
   function automatic exp_t ref_decode(input logic [31:0] inst, input logic [63:0] pc,
                                       input logic [63:0] d1, input logic [63:0] d2);
      exp_t e;
      logic [63:0] r1, r2, imm, opb;
      int hit;
      r1 = (inst[19:15] == 5'd0) ? 64'd0 : d1;
      r2 = (inst[24:20] == 5'd0) ? 64'd0 : d2;
      hit = -1;
      for (int i = 0; i < tbl.size(); i++)
         if (hit < 0 && (inst & tbl[i].mask) == tbl[i].match) hit = i;
      e.pc = pc; e.f3 = inst[14:12]; e.rd = inst[11:7]; e.sd = r2;
      e.aluop = 4'd0; e.op1 = 64'd0; e.op2 = 64'd0; e.imm = 64'd0;
      e.cls = 3'd0; e.word = 1'b0; e.wen = 1'b0; e.ill = (hit < 0); e.ik = 0;
      if (hit >= 0) begin
         case (tbl[hit].ik)
            1: imm = sx({20'h0, inst[31:20]}, 12);
            2: imm = sx({20'h0, inst[31:25], inst[11:7]}, 12);
            3: imm = sx({19'h0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13);
            4: imm = sx({inst[31:12], 12'h000}, 32);
            5: imm = sx({11'h0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21);
            default: imm = 64'd0;
         endcase
         case (tbl[hit].b)
            0: opb = r2;
            1: opb = imm;
            2: opb = 64'd4;
            3: opb = 64'(inst[25:20]);
            default: opb = 64'(inst[24:20]);
         endcase
         e.op1   = (tbl[hit].a == 0) ? r1 : (tbl[hit].a == 1) ? pc : 64'd0;
         e.op2   = opb;
         e.imm   = imm;
         e.ik    = tbl[hit].ik;
         e.aluop = tbl[hit].aluop;
         e.cls   = 3'(tbl[hit].cls);
         e.word  = tbl[hit].word;
         e.wen   = tbl[hit].wr && (inst[11:7] != 5'd0);
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      if (m_known) begin
         chk("ex_valid", 64'(bus.ex_valid), 64'(m_valid));
         if (m_zero) begin
            chk("rst_aluop", 64'(bus.ex_aluop), 64'd0);  chk("rst_op1", bus.ex_op1, 64'd0);
            chk("rst_op2", bus.ex_op2, 64'd0);           chk("rst_imm", bus.ex_imm, 64'd0);
            chk("rst_pc", bus.ex_pc, 64'd0);             chk("rst_sd", bus.ex_store_data, 64'd0);
            chk("rst_rd", 64'(bus.ex_rd), 64'd0);        chk("rst_wen", 64'(bus.ex_wen), 64'd0);
            chk("rst_class", 64'(bus.ex_class), 64'd0);  chk("rst_f3", 64'(bus.ex_funct3), 64'd0);
            chk("rst_word", 64'(bus.ex_word), 64'd0);    chk("rst_ill", 64'(bus.ex_illegal), 64'd0);
         end else if (m_valid) begin
            chk("illegal", 64'(bus.ex_illegal), 64'(m_exp.ill));
            chk("wen", 64'(bus.ex_wen), 64'(m_exp.wen));
            chk("aluop", 64'(bus.ex_aluop), 64'(m_exp.aluop));
            chk("pc", bus.ex_pc, m_exp.pc);
            chk("funct3", 64'(bus.ex_funct3), 64'(m_exp.f3));
            if (!m_exp.ill) begin
               chk("class", 64'(bus.ex_class), 64'(m_exp.cls));
               chk("word", 64'(bus.ex_word), 64'(m_exp.word));
               chk("op1", bus.ex_op1, m_exp.op1);
               chk("op2", bus.ex_op2, m_exp.op2);
               if (m_exp.wen) chk("rd", 64'(bus.ex_rd), 64'(m_exp.rd));
               if (m_exp.ik != 0) chk("imm", bus.ex_imm, m_exp.imm);
               if (m_exp.cls == 3'd2) chk("store_data", bus.ex_store_data, m_exp.sd);
            end
         end
      end
   endtask

   // One clock: check the slot, drive new inputs, check combinational outputs, advance the model.
   task automatic cyc(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                      input logic [63:0] d1, input logic [63:0] d2,
                      input logic rdy, input logic fl, input logic r);
      bit rdy_m;
      @(negedge clk);
      compare_all();
      bus.in_valid = v; bus.in_inst = inst; bus.in_pc = pc;
      bus.rs1_data = d1; bus.rs2_data = d2; bus.ex_ready = rdy; bus.flush = fl; rst = r;
      #1;
      chk("rs1_addr", 64'(bus.rs1_addr), 64'(inst[19:15]));
      chk("rs2_addr", 64'(bus.rs2_addr), 64'(inst[24:20]));
      rdy_m = !m_valid || rdy;
      if (m_known) chk("in_ready", 64'(bus.in_ready), 64'(rdy_m));
      if (r) begin
         m_known = 1'b1; m_zero = 1'b1; m_valid = 1'b0;
      end else if (fl) begin
         m_valid = 1'b0;
      end else if (rdy_m) begin
         m_valid = v;
         if (v) begin
            m_exp  = ref_decode(inst, pc, d1, d2);
            m_zero = 1'b0;
         end
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] I_ADD   = 32'h002081B3;  // add  x3,x1,x2
   localparam logic [31:0] I_SRAI  = 32'h43F0D213;  // srai x4,x1,63
   localparam logic [31:0] I_ADDI  = 32'hC0008093;  // addi x1,x1,-1024
   localparam logic [31:0] I_BLTU  = 32'hFE20ECE3;  // bltu x1,x2,-8
   localparam logic [31:0] I_LUI   = 32'h800002B7;  // lui  x5,0x80000
   localparam logic [31:0] I_ADDX0 = 32'h00200333;  // add  x6,x0,x2
   localparam logic [31:0] I_ADDRD = 32'h00208033;  // add  x0,x1,x2

   initial begin
      logic [31:0] inst;
      int k;
      total = 0; bad = 0; m_valid = 1'b0; m_zero = 1'b0; m_known = 1'b0;
      rst = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_inst = 32'h0; bus.in_pc = 64'h0;
      bus.rs1_data = 64'h0; bus.rs2_data = 64'h0; bus.ex_ready = 1'b1;

      add(MU, 32'h37, 4'h0, 0, 2, 1, 4, 0, 1);  add(MU, 32'h17, 4'h0, 0, 1, 1, 4, 0, 1);
      add(MU, 32'h6F, 4'h0, 4, 1, 2, 5, 0, 1);  add(MI, 32'h67, 4'h0, 5, 1, 2, 1, 0, 1);
      for (int f = 0; f < 8; f++)
         if (f != 2 && f != 3) add(MI, 32'h63 | (f << 12), (f >= 6) ? 4'hE : 4'hC, 3, 0, 0, 3, 0, 0);
      for (int f = 0; f < 7; f++) add(MI, 32'h03 | (f << 12), 4'h0, 1, 0, 1, 1, 0, 1);
      for (int f = 0; f < 4; f++) add(MI, 32'h23 | (f << 12), 4'h0, 2, 0, 1, 2, 0, 0);
      add(MI, 32'h0013, 4'h0, 0, 0, 1, 1, 0, 1);  add(MI, 32'h2013, 4'hC, 0, 0, 1, 1, 0, 1);
      add(MI, 32'h3013, 4'hE, 0, 0, 1, 1, 0, 1);  add(MI, 32'h4013, 4'h4, 0, 0, 1, 1, 0, 1);
      add(MI, 32'h6013, 4'h6, 0, 0, 1, 1, 0, 1);  add(MI, 32'h7013, 4'h7, 0, 0, 1, 1, 0, 1);
      add(MS, 32'h1013, 4'h8, 0, 0, 3, 1, 0, 1);  add(MS, 32'h5013, 4'h9, 0, 0, 3, 1, 0, 1);
      add(MS, 32'h40005013, 4'hB, 0, 0, 3, 1, 0, 1);
      add(MI, 32'h001B, 4'h0, 0, 0, 1, 1, 1, 1);  add(MR, 32'h101B, 4'h8, 0, 0, 4, 1, 1, 1);
      add(MR, 32'h501B, 4'h9, 0, 0, 4, 1, 1, 1);  add(MR, 32'h4000501B, 4'hB, 0, 0, 4, 1, 1, 1);
      add(MR, 32'h0033, 4'h0, 0, 0, 0, 0, 0, 1);  add(MR, 32'h40000033, 4'h1, 0, 0, 0, 0, 0, 1);
      add(MR, 32'h1033, 4'h8, 0, 0, 0, 0, 0, 1);  add(MR, 32'h2033, 4'hC, 0, 0, 0, 0, 0, 1);
      add(MR, 32'h3033, 4'hE, 0, 0, 0, 0, 0, 1);  add(MR, 32'h4033, 4'h4, 0, 0, 0, 0, 0, 1);
      add(MR, 32'h5033, 4'h9, 0, 0, 0, 0, 0, 1);  add(MR, 32'h40005033, 4'hB, 0, 0, 0, 0, 0, 1);
      add(MR, 32'h6033, 4'h6, 0, 0, 0, 0, 0, 1);  add(MR, 32'h7033, 4'h7, 0, 0, 0, 0, 0, 1);
      add(MR, 32'h003B, 4'h0, 0, 0, 0, 0, 1, 1);  add(MR, 32'h4000003B, 4'h1, 0, 0, 0, 0, 1, 1);
      add(MR, 32'h103B, 4'h8, 0, 0, 0, 0, 1, 1);  add(MR, 32'h503B, 4'h9, 0, 0, 0, 0, 1, 1);
      add(MR, 32'h4000503B, 4'hB, 0, 0, 0, 0, 1, 1);

      cyc(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1);
      settle();
      chk("lit_reset_valid", 64'(bus.ex_valid), 64'd0);
      chk("lit_reset_ready", 64'(bus.in_ready), 64'd1);

      cyc(1'b1, I_ADD, 64'h1000, 64'd5, 64'd7, 1'b1, 1'b0, 1'b0);
      settle();
      chk("lit_add_valid", 64'(bus.ex_valid), 64'd1);  chk("lit_add_aluop", 64'(bus.ex_aluop), 64'h0);
      chk("lit_add_op1", bus.ex_op1, 64'd5);           chk("lit_add_op2", bus.ex_op2, 64'd7);
      chk("lit_add_rd", 64'(bus.ex_rd), 64'd3);        chk("lit_add_wen", 64'(bus.ex_wen), 64'd1);

      for (int i = 0; i < 3; i++)
         cyc(1'b1, I_SRAI, 64'h1004, 64'h8000_0000_0000_0000, 64'd9, 1'b0, 1'b0, 1'b0);
      settle();
      chk("lit_stall_ready", 64'(bus.in_ready), 64'd0);
      chk("lit_stall_rd", 64'(bus.ex_rd), 64'd3);
      cyc(1'b1, I_SRAI, 64'h1004, 64'h8000_0000_0000_0000, 64'd9, 1'b1, 1'b0, 1'b0);
      settle();
      chk("lit_srai_aluop", 64'(bus.ex_aluop), 64'hB);  chk("lit_srai_op2", bus.ex_op2, 64'd63);
      chk("lit_srai_rd", 64'(bus.ex_rd), 64'd4);

      cyc(1'b1, I_ADDI, 64'h1008, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0);
      settle();
      chk("lit_addi_aluop", 64'(bus.ex_aluop), 64'h0);
      chk("lit_addi_op2", bus.ex_op2, 64'hFFFF_FFFF_FFFF_FC00);
      cyc(1'b1, I_BLTU, 64'h100, 64'd1, 64'd2, 1'b1, 1'b0, 1'b0);
      settle();
      chk("lit_bltu_aluop", 64'(bus.ex_aluop), 64'hE);  chk("lit_bltu_class", 64'(bus.ex_class), 64'd3);
      chk("lit_bltu_wen", 64'(bus.ex_wen), 64'd0);      chk("lit_bltu_imm", bus.ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
      cyc(1'b1, I_LUI, 64'h104, 64'h55, 64'h66, 1'b1, 1'b0, 1'b0);
      settle();
      chk("lit_lui_op1", bus.ex_op1, 64'd0);  chk("lit_lui_op2", bus.ex_op2, 64'hFFFF_FFFF_8000_0000);
      cyc(1'b1, I_ADDX0, 64'h108, 64'hDEAD, 64'd3, 1'b1, 1'b0, 1'b0);
      settle();
      chk("lit_x0_op1", bus.ex_op1, 64'd0);
      cyc(1'b1, I_ADDRD, 64'h10C, 64'd1, 64'd2, 1'b1, 1'b0, 1'b0);
      settle();
      chk("lit_rd0_wen", 64'(bus.ex_wen), 64'd0);
      cyc(1'b1, 32'h0000007F, 64'h110, 64'd1, 64'd2, 1'b1, 1'b0, 1'b0);
      settle();
      chk("lit_ill_flag", 64'(bus.ex_illegal), 64'd1);  chk("lit_ill_valid", 64'(bus.ex_valid), 64'd1);
      chk("lit_ill_wen", 64'(bus.ex_wen), 64'd0);       chk("lit_ill_aluop", 64'(bus.ex_aluop), 64'd0);

      cyc(1'b1, I_ADD, 64'h114, 64'd5, 64'd7, 1'b1, 1'b1, 1'b0);
      settle();
      chk("lit_flush_valid", 64'(bus.ex_valid), 64'd0);

      cyc(1'b1, I_ADD, 64'h118, 64'd5, 64'd7, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, I_SRAI, 64'h11C, 64'd1, 64'd1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, I_SRAI, 64'h11C, 64'd1, 64'd1, 1'b0, 1'b0, 1'b1);
      settle();
      chk("lit_rststall_valid", 64'(bus.ex_valid), 64'd0);
      chk("lit_rststall_op1", bus.ex_op1, 64'd0);
      chk("lit_rststall_rd", 64'(bus.ex_rd), 64'd0);
      chk("lit_rststall_ready", 64'(bus.in_ready), 64'd1);

      for (int n = 0; n < 800; n++) begin
         k = $urandom_range(0, tbl.size() - 1);
         inst = ($urandom_range(0, 9) == 0) ? $urandom : (tbl[k].match | ($urandom & ~tbl[k].mask));
         if ($urandom_range(0, 9) == 0) inst[19:15] = 5'd0;
         if ($urandom_range(0, 9) == 0) inst[24:20] = 5'd0;
         cyc($urandom_range(0, 3) != 0, inst, {$urandom, $urandom} & ~64'h3,
             {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
      end
      cyc(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
